// File: rtl/uart_axi_sequencer.sv
// uart_axi_sequencer
//   AXI-lite master that owns the UART slave. After reset it programs CTRL
//   once. It then polls STATUS and moves bytes between the byte ports and
//   the TX/RX data registers. It never writes a full TX FIFO and never reads
//   an empty RX FIFO.
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   m_axi_ar*/r*        read channel; arvalid is a single-cycle pulse
//   m_axi_aw*/w*/b*     write channel; awvalid and wvalid pulse together
//   read_size_o         1111 for STATUS reads, 0001 for RDATA reads
//   tx_byte_i/valid_i   byte to send; tx_ready_o when the holding reg is free
//   rx_byte_o/valid_o   received byte, held until rx_ready_i
//   err_o               one-cycle pulse on response timeout
//   init_done_o         CTRL has been programmed
//
// state    | meaning
// INIT_REQ | issue CTRL write
// INIT_RSP | wait bvalid for CTRL write
// IDLE     | count poll interval, or poll now if a tx byte is waiting
// ST_REQ   | issue STATUS read
// ST_RSP   | wait rvalid, choose TX / RX / nothing
// TX_REQ   | issue WDATA write
// TX_RSP   | wait bvalid, free tx holding register
// RX_REQ   | issue RDATA read
// RX_RSP   | wait rvalid, fill rx holding register
module uart_axi_sequencer #(
  parameter logic [31:0] UART_BASE_ADDR = 32'h2000_0000,
  parameter logic [15:0] BAUD_DIV       = 16'd868,
  parameter int unsigned POLL_INTERVAL  = 16,
  parameter int unsigned TIMEOUT        = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] m_axi_araddr_o,
  output logic        m_axi_arvalid_o,
  input  logic        m_axi_arready_i,
  output logic        m_axi_rready_o,
  input  logic        m_axi_rvalid_i,
  input  logic [31:0] m_axi_rdata_i,
  output logic [31:0] m_axi_awaddr_o,
  output logic        m_axi_awvalid_o,
  input  logic        m_axi_awready_i,
  output logic [31:0] m_axi_wdata_o,
  output logic [3:0]  m_axi_wstrb_o,
  output logic        m_axi_wvalid_o,
  input  logic        m_axi_wready_i,
  output logic        m_axi_bready_o,
  input  logic        m_axi_bvalid_i,
  output logic [3:0]  read_size_o,
  input  logic [7:0]  tx_byte_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_byte_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        err_o,
  output logic        init_done_o
);

  typedef enum logic [3:0] {
    INIT_REQ, INIT_RSP, IDLE, ST_REQ, ST_RSP, TX_REQ, TX_RSP, RX_REQ, RX_RSP
  } state_t;

  localparam logic [15:0] POLL_LAST = 16'(POLL_INTERVAL - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] poll_cnt_q, poll_cnt_d, to_cnt_q, to_cnt_d;
  logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d, read_size_q, read_size_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [7:0]  tx_hold_q, tx_hold_d, rx_hold_q, rx_hold_d;
  logic        tx_full_q, tx_full_d, tx_ready_q, tx_ready_d;
  logic        rx_full_q, rx_full_d, err_q, err_d;
  logic        init_done_q, init_done_d, prio_q, prio_d;

  logic r_done, b_done, tmo, tx_elig, rx_elig;

  // Handshake-only inputs: the slave is always ready.
  logic unused_in;
  assign unused_in = &{1'b0, m_axi_arready_i, m_axi_awready_i, m_axi_wready_i,
                       m_axi_rdata_i[31:8]};

  assign r_done  = rready_q && m_axi_rvalid_i;
  assign b_done  = bready_q && m_axi_bvalid_i;
  assign tmo     = (to_cnt_q == TO_LAST);
  // rdata[3:0] = {rx_empty, rx_full, tx_empty, tx_full}
  assign tx_elig = tx_full_q && !m_axi_rdata_i[0];
  assign rx_elig = !m_axi_rdata_i[3] && !rx_full_q;

  always_comb begin
    state_d     = state_q;
    poll_cnt_d  = '0;
    to_cnt_d    = to_cnt_q + 16'd1;
    araddr_d    = araddr_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    read_size_d = read_size_q;
    arvalid_d   = 1'b0;
    awvalid_d   = 1'b0;
    wvalid_d    = 1'b0;
    rready_d    = rready_q && !m_axi_rvalid_i;
    bready_d    = bready_q && !m_axi_bvalid_i;
    tx_hold_d   = tx_hold_q;
    tx_full_d   = tx_full_q;
    rx_hold_d   = rx_hold_q;
    rx_full_d   = rx_full_q;
    err_d       = 1'b0;
    init_done_d = init_done_q;
    prio_d      = prio_q;

    if (tx_valid_i && tx_ready_q) begin
      tx_hold_d = tx_byte_i;
      tx_full_d = 1'b1;
    end
    if (rx_full_q && rx_ready_i) rx_full_d = 1'b0;

    case (state_q)
      INIT_REQ: begin
        awaddr_d  = UART_BASE_ADDR;
        wdata_d   = {BAUD_DIV, 14'b0, 2'b11};
        wstrb_d   = 4'b1111;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        bready_d  = 1'b1;
        to_cnt_d  = '0;
        state_d   = INIT_RSP;
      end
      INIT_RSP: begin
        if (b_done) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else if (tmo) begin
          err_d    = 1'b1;
          bready_d = 1'b0;
          state_d  = INIT_REQ;
        end
      end
      IDLE: begin
        if (tx_full_q || poll_cnt_q == POLL_LAST) state_d = ST_REQ;
        else poll_cnt_d = poll_cnt_q + 16'd1;
      end
      ST_REQ, RX_REQ: begin
        araddr_d    = UART_BASE_ADDR + ((state_q == ST_REQ) ? 32'h4 : 32'h8);
        read_size_d = (state_q == ST_REQ) ? 4'b1111 : 4'b0001;
        arvalid_d   = 1'b1;
        rready_d    = 1'b1;
        to_cnt_d    = '0;
        state_d     = (state_q == ST_REQ) ? ST_RSP : RX_RSP;
      end
      ST_RSP: begin
        if (r_done) begin
          // prio_q = 1 means TX was the last side served in a tie.
          if (tx_elig && rx_elig) begin
            state_d = prio_q ? RX_REQ : TX_REQ;
            prio_d  = !prio_q;
          end else if (tx_elig) state_d = TX_REQ;
          else if (rx_elig)     state_d = RX_REQ;
          else                  state_d = IDLE;
        end else if (tmo) begin
          err_d    = 1'b1;
          rready_d = 1'b0;
          state_d  = IDLE;
        end
      end
      TX_REQ: begin
        awaddr_d  = UART_BASE_ADDR + 32'hC;
        wdata_d   = {24'b0, tx_hold_q};
        wstrb_d   = 4'b0001;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        bready_d  = 1'b1;
        to_cnt_d  = '0;
        state_d   = TX_RSP;
      end
      TX_RSP: begin
        if (b_done) begin
          tx_full_d = 1'b0;
          state_d   = IDLE;
        end else if (tmo) begin
          err_d    = 1'b1;
          bready_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RX_RSP: begin
        if (r_done) begin
          rx_hold_d = m_axi_rdata_i[7:0];
          rx_full_d = 1'b1;
          state_d   = IDLE;
        end else if (tmo) begin
          err_d    = 1'b1;
          rready_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = INIT_REQ;
    endcase

    tx_ready_d = init_done_d && !tx_full_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT_REQ;
      poll_cnt_q  <= '0;
      to_cnt_q    <= '0;
      araddr_q    <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      read_size_q <= '0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
      tx_hold_q   <= '0;
      tx_full_q   <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_hold_q   <= '0;
      rx_full_q   <= 1'b0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      poll_cnt_q  <= poll_cnt_d;
      to_cnt_q    <= to_cnt_d;
      araddr_q    <= araddr_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      read_size_q <= read_size_d;
      arvalid_q   <= arvalid_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      rready_q    <= rready_d;
      bready_q    <= bready_d;
      tx_hold_q   <= tx_hold_d;
      tx_full_q   <= tx_full_d;
      tx_ready_q  <= tx_ready_d;
      rx_hold_q   <= rx_hold_d;
      rx_full_q   <= rx_full_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
      prio_q      <= prio_d;
    end
  end

  assign m_axi_araddr_o  = araddr_q;
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_rready_o  = rready_q;
  assign m_axi_awaddr_o  = awaddr_q;
  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = wstrb_q;
  assign m_axi_wvalid_o  = wvalid_q;
  assign m_axi_bready_o  = bready_q;
  assign read_size_o     = read_size_q;
  assign tx_ready_o      = tx_ready_q;
  assign rx_byte_o       = rx_hold_q;
  assign rx_valid_o      = rx_full_q;
  assign err_o           = err_q;
  assign init_done_o     = init_done_q;

endmodule

// File: doc/uart_axi_sequencer.md
Name: uart_axi_sequencer

Overview:
AXI-lite master that owns the UART peripheral slave at UART_BASE_ADDR. After reset it programs the UART control register once. It then polls the UART status register and moves bytes between simple valid/ready byte ports and the UART TX/RX data registers. It replaces direct core access for boot/console traffic and ensures the slave never sees a write to a full TX FIFO or a read from an empty RX FIFO.

Parameters:
UART_BASE_ADDR, 32'h2000_0000, peripheral base; CTRL +0x0, STATUS +0x4, RDATA +0x8, WDATA +0xC
BAUD_DIV, 16'd868, written to ctrl[31:16]
POLL_INTERVAL, 16, idle cycles between unsolicited status polls (>=2)
TIMEOUT, 64, max cycles waiting for rvalid/bvalid

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
m_axi_araddr_o  out  32  read address
m_axi_arvalid_o  out  1  read request, one-cycle pulse
m_axi_arready_i  in  1  ignored (slave is always-ready)
m_axi_rready_o  out  1  read-data ready
m_axi_rvalid_i  in  1  read data valid
m_axi_rdata_i  in  32  read data
m_axi_awaddr_o  out  32  write address
m_axi_awvalid_o  out  1  write address valid, one-cycle pulse
m_axi_awready_i  in  1  ignored
m_axi_wdata_o  out  32  write data
m_axi_wstrb_o  out  4  byte strobes
m_axi_wvalid_o  out  1  write data valid, pulsed with awvalid
m_axi_wready_i  in  1  ignored
m_axi_bready_o  out  1  write response ready
m_axi_bvalid_i  in  1  write response
read_size_o  out  4  1111 for STATUS reads, 0001 for RDATA reads
tx_byte_i  in  8  byte to send
tx_valid_i  in  1  tx byte offered
tx_ready_o  out  1  tx holding register empty and init done
rx_byte_o  out  8  received byte
rx_valid_o  out  1  rx holding register full
rx_ready_i  in  1  consumer takes rx byte
err_o  out  1  one-cycle pulse on response timeout
init_done_o  out  1  ctrl programmed

Behaviour:
- Reset: all outputs 0; addr/data/strb 0; holding registers empty; FSM in INIT_REQ; poll counter and priority bit 0. Reset mid-transaction abandons it without draining.
- Request rule: a request is issued only when a transaction is made. The cycle it is made, arvalid and rready are asserted together for exactly 1 cycle (or awvalid, wvalid and bready for exactly 1 cycle). rready/bready then stay high until rvalid/bvalid is seen. A held arvalid would pop RDATA repeatedly and is forbidden.
- FSM:
  - INIT_REQ: write CTRL = {BAUD_DIV,14'b0,2'b11}, strb 1111 -> INIT_RSP.
  - INIT_RSP: on bvalid -> IDLE and set init_done_o.
  - IDLE: go to ST_REQ if tx holding is full or the poll counter reaches POLL_INTERVAL-1.
  - ST_REQ: read STATUS -> ST_RSP.
  - ST_RSP: latch rdata[3:0] as {rx_empty,rx_full,tx_empty,tx_full}, then decide:
    - TX eligible = tx holding full and !tx_full.
    - RX eligible = !rx_empty and rx holding empty.
    - If both are eligible, serve the side opposite the priority bit and toggle the bit.
    - Go to TX_REQ, RX_REQ or IDLE.
  - TX_REQ: write WDATA = {24'b0,tx_hold}, strb 0001 -> TX_RSP.
  - TX_RSP: on bvalid, empty tx holding -> IDLE.
  - RX_REQ: read RDATA -> RX_RSP.
  - RX_RSP: on rvalid, load rdata[7:0] into rx holding, set rx_valid_o -> IDLE.
- Timeout: in any *_RSP state, a cycle counter reaching TIMEOUT-1 pulses err_o, drops ready and returns to IDLE. INIT_RSP returns to INIT_REQ instead. Holding registers are unchanged (TX is retried).
- tx handshake: accept on tx_valid_i && tx_ready_o. tx_ready_o = init_done && tx holding empty, registered. Accept and drain are never in the same cycle.
- rx handshake: rx_valid_o holds until rx_ready_i. The holding register may be refilled the cycle after it is consumed.
- Poll counter: counts only in IDLE and resets on leaving IDLE. It wraps at POLL_INTERVAL-1 and does not saturate.
- No back-to-back requests: at least 1 cycle always separates a response from the next request.

Test Plan:
- Reset, slave model bvalid 1 cycle after aw -> single write 0x2000_0000 data 0x0364_0003 strb 1111; init_done_o=1 at cycle 3; exactly one awvalid pulse.
- tx_byte 0x41 offered, status returns 0x2 (tx_empty, not full) -> STATUS read (read_size 1111) then WDATA write 0x2000_000C data 0x41 strb 0001; tx_ready_o returns 1 after bvalid.
- Status returns 0x1 (tx_full) repeatedly with a tx byte pending -> no WDATA write; status re-polled until 0x0, then write issued.
- Status 0x0, rx holding empty, slave rdata 0x5A -> RDATA read with read_size 0001 and a single arvalid pulse; rx_valid_o=1, rx_byte_o=0x5A held while rx_ready_i=0.
- Both TX and RX eligible on 4 consecutive polls -> service order alternates TX, RX, TX, RX.
- Slave never returns rvalid -> err_o pulses once after 64 cycles; FSM back to IDLE; rst_i asserted mid TX_RSP -> all outputs 0 next cycle and init sequence re-runs.
